// File: rtl/rx_comma_align.sv
// rx_comma_align: finds the K28.5 comma boundary in a 10-bit unaligned
// receive stream, aligns the stream to it and tracks sync with a
// HUNT / CHECK / LOCKED state machine.
//
// Ports:
//   Clk          in   rising-edge clock
//   notReset     in   synchronous active-low reset
//   RawIn[9:0]   in   unaligned received bits, bit 9 earliest
//   RxElecIdle   in   electrical idle, forces loss of sync
//   LinkIn[9:0]  out  registered word-aligned code group
//   Synced       out  registered, high while alignment is locked
//   CommaDet     out  registered, high when LinkIn is a comma
//   AlignOffset  out  registered locked bit offset 0..9
module rx_comma_align #(
  parameter logic [9:0]  PCOMMA         = 10'b0011111010,
  parameter logic [9:0]  NCOMMA         = 10'b1100000101,
  parameter int unsigned SYNC_COMMAS    = 4,
  parameter int unsigned MAX_GAP        = 2047,
  parameter int unsigned MISALIGN_LIMIT = 2
) (
  input  logic       Clk,
  input  logic       notReset,
  input  logic [9:0] RawIn,
  input  logic       RxElecIdle,
  output logic [9:0] LinkIn,
  output logic       Synced,
  output logic       CommaDet,
  output logic [3:0] AlignOffset
);

  localparam int unsigned WORD_W  = 10;
  localparam int unsigned NUM_OFF = 10;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned GAP_W   = 12;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MIS_W   = 2;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WORD_W-1:0]  raw_last;
  logic [2*WORD_W-1:0] window;
  logic [WORD_W-1:0]  cand [NUM_OFF];
  logic [NUM_OFF-1:0] is_comma;
  logic               any_comma;
  logic               found;
  logic [OFF_W-1:0]   low_off;
  logic [WORD_W-1:0]  lock_word;
  logic               lock_hit;

  logic [CNT_W-1:0]   comma_cnt, comma_cnt_n, cnt_inc;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n, gap_inc;
  logic [MIS_W-1:0]   mis_cnt, mis_cnt_n, mis_inc;
  logic [OFF_W-1:0]   off_n;
  logic               gap_hit, cnt_done, mis_hit;

  // Candidate words at every bit offset and the lowest comma offset.
  always_comb begin
    window    = {raw_last, RawIn};
    is_comma  = '0;
    low_off   = '0;
    found     = 1'b0;
    lock_word = '0;
    lock_hit  = 1'b0;
    for (int k = 0; k < NUM_OFF; k++) begin
      cand[k]     = window[(2*WORD_W-1-k) -: WORD_W];
      is_comma[k] = (cand[k] == PCOMMA) || (cand[k] == NCOMMA);
      if (is_comma[k] && !found) begin
        low_off = OFF_W'(k);
        found   = 1'b1;
      end
      if (AlignOffset == OFF_W'(k)) begin
        lock_word = cand[k];
        lock_hit  = is_comma[k];
      end
    end
    any_comma = |is_comma;
  end

  // Saturating increments and their thresholds.
  always_comb begin
    gap_inc  = (gap_cnt == '1)   ? gap_cnt   : gap_cnt + GAP_W'(1);
    cnt_inc  = (comma_cnt == '1) ? comma_cnt : comma_cnt + CNT_W'(1);
    mis_inc  = (mis_cnt == '1)   ? mis_cnt   : mis_cnt + MIS_W'(1);
    gap_hit  = (gap_inc >= GAP_W'(MAX_GAP));
    cnt_done = (cnt_inc >= CNT_W'(SYNC_COMMAS));
    mis_hit  = (mis_inc >= MIS_W'(MISALIGN_LIMIT));
  end

  // Next-state and counter logic; the locked offset always wins over a
  // comma seen elsewhere in the same window.
  always_comb begin
    state_n     = state;
    comma_cnt_n = comma_cnt;
    gap_cnt_n   = gap_cnt;
    mis_cnt_n   = mis_cnt;
    off_n       = AlignOffset;

    case (state)
      HUNT: begin
        if (any_comma) begin
          off_n       = low_off;
          comma_cnt_n = CNT_W'(1);
          gap_cnt_n   = '0;
          mis_cnt_n   = '0;
          state_n     = (SYNC_COMMAS == 1) ? LOCKED : CHECK;
        end
      end

      CHECK: begin
        if (lock_hit) begin
          comma_cnt_n = cnt_inc;
          gap_cnt_n   = '0;
          if (cnt_done) begin
            state_n = LOCKED;
          end
        end else if (any_comma) begin
          off_n       = low_off;
          comma_cnt_n = CNT_W'(1);
          gap_cnt_n   = '0;
        end else begin
          gap_cnt_n = gap_inc;
          if (gap_hit) begin
            state_n = HUNT;
          end
        end
      end

      LOCKED: begin
        if (lock_hit) begin
          gap_cnt_n = '0;
          mis_cnt_n = '0;
        end else begin
          // The word at the locked offset is not a comma, so it counts
          // toward the gap whether or not a foreign comma is present.
          gap_cnt_n = gap_inc;
          if (any_comma) begin
            mis_cnt_n = mis_inc;
          end
          if ((any_comma && mis_hit) || gap_hit) begin
            state_n = HUNT;
          end
        end
      end

      default: begin
        state_n = HUNT;
      end
    endcase

    // Counters restart from zero whenever sync is lost.
    if (state_n == HUNT && state != HUNT) begin
      comma_cnt_n = '0;
      gap_cnt_n   = '0;
      mis_cnt_n   = '0;
    end

    if (RxElecIdle) begin
      state_n     = HUNT;
      comma_cnt_n = '0;
      gap_cnt_n   = '0;
      mis_cnt_n   = '0;
      off_n       = AlignOffset;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (!notReset) begin
      state       <= HUNT;
      raw_last    <= '0;
      LinkIn      <= '0;
      CommaDet    <= 1'b0;
      Synced      <= 1'b0;
      AlignOffset <= '0;
      comma_cnt   <= '0;
      gap_cnt     <= '0;
      mis_cnt     <= '0;
    end else begin
      state       <= state_n;
      raw_last    <= RawIn;
      LinkIn      <= lock_word;
      CommaDet    <= lock_hit;
      Synced      <= (state_n == LOCKED);
      AlignOffset <= off_n;
      comma_cnt   <= comma_cnt_n;
      gap_cnt     <= gap_cnt_n;
      mis_cnt     <= mis_cnt_n;
    end
  end

endmodule
